regfile_sb: RTL and testbench

Parametrised multi-port register file with an integrated write-pending scoreboard. It is the successor to the 32x32 two-read/one-write register bank in the datapath. Over that bank it adds a second write port, N read ports, optional same-cycle write-to-read bypass, a hardwired-zero register option and per-register busy tracking. Issue logic uses the busy tracking to hold operands until writeback.

---
 rtl/regfile_sb.sv | 113 +++++++++++
 tb/tb_regfile_sb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file (two write ports, N_RD read ports)
// with a per-register write-pending scoreboard used by issue logic to hold
// operands until their producing write has landed.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   input  logic [N_RD*ADDR_W-1:0]   ra,
   output logic [N_RD*DATA_W-1:0]   rd,
   output logic [N_RD-1:0]          rbusy,
   input  logic                     alloc_en,
   input  logic [ADDR_W-1:0]        alloc_addr,
   output logic                     alloc_ok,
   output logic [ADDR_W:0]          n_busy,
   output logic                     wconf_err
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CNT_W = ADDR_W + 1;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [CNT_W-1:0]  n_busy_q, n_busy_d;
   logic              wconf_q, wconf_d;

   logic alloc_zero;
   logic alloc_hit_wr;

   // Allocation is accepted when the target is free or is being written back
   // this very cycle; register 0 is always accepted when hardwired to zero.
   assign alloc_zero   = ZR && (alloc_addr == '0);
   assign alloc_hit_wr = (we0 && (wa0 == alloc_addr)) || (we1 && (wa1 == alloc_addr));
   assign alloc_ok     = alloc_en && (alloc_zero || !busy_q[alloc_addr] || alloc_hit_wr);

   // Storage next state: port 1 is applied after port 0 so it wins a conflict.
   always_comb begin
      // NOTE: defaults first, then overrides with blocking '=' -- every path
      // assigns mem_d, so no latch, and the later port-1 write takes priority.
      mem_d = mem_q;
      if (we0) mem_d[wa0] = wd0;
      if (we1) mem_d[wa1] = wd1;
      if (ZR)  mem_d[0]   = '0;
   end

   // Scoreboard next state: writes clear, an accepted allocation sets and
   // beats a same-cycle clear; the count is the popcount of the new bits.
   always_comb begin
      busy_d = busy_q;
      if (we0)      busy_d[wa0]        = 1'b0;
      if (we1)      busy_d[wa1]        = 1'b0;
      if (alloc_ok) busy_d[alloc_addr] = 1'b1;
      if (ZR)       busy_d[0]          = 1'b0;
      n_busy_d = '0;
      for (int r = 0; r < DEPTH; r++) begin
         n_busy_d = n_busy_d + CNT_W'(busy_d[r]);
      end
      wconf_d = wconf_q || (we0 && we1 && (wa0 == wa1) && !(ZR && (wa0 == '0)));
   end

   // State registers; reset is asynchronous and discards any in-flight update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the storage array is reset on purpose -- registers must read
         // zero after reset, so it cannot be left as an unreset RAM.
         mem_q    <= '{default: '0};
         busy_q   <= '0;
         n_busy_q <= '0;
         wconf_q  <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         busy_q   <= busy_d;
         n_busy_q <= n_busy_d;
         wconf_q  <= wconf_d;
      end
   end

   assign n_busy    = n_busy_q;
   assign wconf_err = wconf_q;

   // Read ports: zero register, then port-1 bypass, then port-0 bypass, then storage.
   for (genvar i = 0; i < N_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              is_zero;
      logic              hit0;
      logic              hit1;

      assign addr    = ra[i*ADDR_W +: ADDR_W];
      assign is_zero = ZR && (addr == '0);
      assign hit0    = BP && we0 && (wa0 == addr);
      assign hit1    = BP && we1 && (wa1 == addr);

      assign rd[i*DATA_W +: DATA_W] = is_zero ? '0  :
                                      hit1    ? wd1 :
                                      hit0    ? wd0 :
                                                mem_q[addr];
      assign rbusy[i] = !is_zero && !hit0 && !hit1 && busy_q[addr];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: drives two register files side by side (instance 0 with
// zero register and bypass, instance 1 with neither) from the same inputs
// and checks every cycle against a behavioural model of each.
module tb_regfile_sb;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int DEPTH = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           we0 = 1'b0, we1 = 1'b0;
   logic [AW-1:0]  wa0 = '0, wa1 = '0;
   logic [DW-1:0]  wd0 = '0, wd1 = '0;
   logic [NR*AW-1:0] ra = '0;
   logic           alloc_en = 1'b0;
   logic [AW-1:0]  alloc_addr = '0;

   logic [NR*DW-1:0] rd_w    [2];
   logic [NR-1:0]    rbusy_w [2];
   logic             ok_w    [2];
   logic [AW:0]      nb_w    [2];
   logic             werr_w  [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd_w[0]), .rbusy(rbusy_w[0]),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(ok_w[0]),
      .n_busy(nb_w[0]), .wconf_err(werr_w[0])
   );

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd_w[1]), .rbusy(rbusy_w[1]),
      .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_ok(ok_w[1]),
      .n_busy(nb_w[1]), .wconf_err(werr_w[1])
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_reg  [2][DEPTH];
   bit            m_busy [2][DEPTH];
   int            m_nbusy[2];
   bit            m_werr [2];

   function automatic bit zr(int d); return d == 0; endfunction
   function automatic bit bp(int d); return d == 0; endfunction

   function automatic bit writes_to(logic [AW-1:0] a);
      return (we0 && wa0 == a) || (we1 && wa1 == a);
   endfunction

   function automatic logic [DW-1:0] exp_rd(int d, logic [AW-1:0] a);
      if (zr(d) && a == 0) return '0;
      if (bp(d) && we1 && wa1 == a) return wd1;
      if (bp(d) && we0 && wa0 == a) return wd0;
      return m_reg[d][a];
   endfunction

   function automatic bit exp_rbusy(int d, logic [AW-1:0] a);
      if (zr(d) && a == 0) return 1'b0;
      if (bp(d) && writes_to(a)) return 1'b0;
      return m_busy[d][a];
   endfunction

   function automatic bit exp_ok(int d);
      if (!alloc_en) return 1'b0;
      if (zr(d) && alloc_addr == 0) return 1'b1;
      return !m_busy[d][alloc_addr] || writes_to(alloc_addr);
   endfunction

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < DEPTH; r++) begin
            m_reg[d][r]  = '0;
            m_busy[d][r] = 1'b0;
         end
         m_nbusy[d] = 0;
         m_werr[d]  = 1'b0;
      end
   endfunction

   function automatic void model_commit();
      for (int d = 0; d < 2; d++) begin
         bit ok;
         int cnt;
         ok = exp_ok(d);
         if (we0 && !(zr(d) && wa0 == 0)) m_reg[d][wa0] = wd0;
         if (we1 && !(zr(d) && wa1 == 0)) m_reg[d][wa1] = wd1;
         if (we0) m_busy[d][wa0] = 1'b0;
         if (we1) m_busy[d][wa1] = 1'b0;
         if (ok && !(zr(d) && alloc_addr == 0)) m_busy[d][alloc_addr] = 1'b1;
         if (we0 && we1 && wa0 == wa1 && !(zr(d) && wa0 == 0)) m_werr[d] = 1'b1;
         cnt = 0;
         for (int r = 0; r < DEPTH; r++) cnt += int'(m_busy[d][r]);
         m_nbusy[d] = cnt;
      end
   endfunction

   // Model state follows the DUT: async reset, otherwise update at the edge.
   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_commit();
   end

   // Compare every output of both instances against the model each cycle.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NR; i++) begin
            logic [AW-1:0] a;
            a = ra[i*AW +: AW];
            check($sformatf("inst%0d rd%0d addr%0d", d, i, a), rd_w[d][i*DW +: DW], exp_rd(d, a));
            check($sformatf("inst%0d rbusy%0d addr%0d", d, i, a), rbusy_w[d][i], exp_rbusy(d, a));
         end
         check($sformatf("inst%0d alloc_ok", d), ok_w[d], exp_ok(d));
         check($sformatf("inst%0d n_busy", d), nb_w[d], m_nbusy[d]);
         check($sformatf("inst%0d wconf_err", d), werr_w[d], m_werr[d]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
      alloc_en = 1'b0; alloc_addr = '0;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) != 0) return AW'($urandom_range(0, 7));
      return AW'($urandom_range(0, DEPTH-1));
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      idle();
      ra = {5'd0, 5'd31};
      step();
      step();
      @(negedge clk);
      check("reset rd0", rd_w[0][31:0], 32'h0);
      check("reset rd1", rd_w[0][63:32], 32'h0);
      check("reset rbusy", rbusy_w[0], 2'b00);
      check("reset n_busy", nb_w[0], 6'd0);
      check("reset wconf_err", werr_w[0], 1'b0);
      step();
      rst = 1'b0;

      // Fill every register with 0x11*r through port 0.
      for (int r = 0; r < DEPTH; r++) begin
         we0 = 1'b1; wa0 = AW'(r); wd0 = 32'h11 * r;
         step();
      end
      idle();
      for (int k = 0; k < DEPTH/2; k++) begin
         ra = {AW'(2*k+1), AW'(2*k)};
         @(negedge clk);
         check($sformatf("readback rd0 k%0d", k), rd_w[0][31:0], 32'h22 * k);
         check($sformatf("readback rd1 k%0d", k), rd_w[0][63:32], 32'h22 * k + 32'h11);
         step();
      end

      // Register 0: hardwired on instance 0, ordinary on instance 1.
      we0 = 1'b1; wa0 = '0; wd0 = 32'hFF; ra = {5'd1, 5'd0};
      @(negedge clk);
      check("zero reg same cycle", rd_w[0][31:0], 32'h0);
      step();
      idle();
      @(negedge clk);
      check("zero reg after write", rd_w[0][31:0], 32'h0);
      check("plain reg0 after write", rd_w[1][31:0], 32'hFF);
      step();

      // Same-cycle bypass from port 1.
      we1 = 1'b1; wa1 = 5'd7; wd1 = 32'hDEADBEEF; ra = {5'd0, 5'd7};
      @(negedge clk);
      check("bypass rd0", rd_w[0][31:0], 32'hDEADBEEF);
      check("no bypass old value", rd_w[1][31:0], 32'h77);
      step();
      idle();
      @(negedge clk);
      check("no bypass new value", rd_w[1][31:0], 32'hDEADBEEF);
      step();

      // Conflict on register 0 is ignored only when it is hardwired.
      we0 = 1'b1; we1 = 1'b1; wa0 = '0; wa1 = '0; wd0 = 32'h1; wd1 = 32'h2;
      step();
      idle();
      @(negedge clk);
      check("zero-addr conflict ignored", werr_w[0], 1'b0);
      check("zero-addr conflict flagged", werr_w[1], 1'b1);
      step();

      // Dual-write conflict on register 5: port 1 wins, flag is sticky.
      we0 = 1'b1; we1 = 1'b1; wa0 = 5'd5; wa1 = 5'd5; wd0 = 32'hAAAA; wd1 = 32'h5555;
      step();
      idle();
      ra = {5'd0, 5'd5};
      @(negedge clk);
      check("conflict winner", rd_w[0][31:0], 32'h5555);
      check("conflict flag", werr_w[0], 1'b1);
      repeat (3) step();
      @(negedge clk);
      check("conflict flag sticky", werr_w[0], 1'b1);
      step();

      // Scoreboard.
      for (int a = 3; a <= 5; a++) begin
         alloc_en = 1'b1; alloc_addr = AW'(a);
         @(negedge clk);
         check($sformatf("alloc %0d ok", a), ok_w[0], 1'b1);
         step();
      end
      idle();
      @(negedge clk);
      check("n_busy after 3 allocs", nb_w[0], 6'd3);
      alloc_en = 1'b1; alloc_addr = 5'd4;
      @(negedge clk);
      check("realloc busy rejected", ok_w[0], 1'b0);
      step();
      we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h44; ra = {5'd0, 5'd4};
      @(negedge clk);
      check("write+alloc accepted", ok_w[0], 1'b1);
      check("rbusy bypassed clear", rbusy_w[0][0], 1'b0);
      check("rbusy no bypass", rbusy_w[1][0], 1'b1);
      step();
      idle();
      @(negedge clk);
      check("n_busy after write+alloc", nb_w[0], 6'd3);
      check("reg4 still busy", rbusy_w[0][0], 1'b1);
      we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33; ra = {5'd0, 5'd3};
      step();
      idle();
      @(negedge clk);
      check("n_busy after writeback", nb_w[0], 6'd2);
      check("reg3 no longer busy", rbusy_w[0][0], 1'b0);
      step();

      // Asynchronous reset between edges with a write pending.
      we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234; ra = {5'd4, 5'd9};
      #1 rst = 1'b1;
      #1;
      check("async rst n_busy", nb_w[0], 6'd0);
      check("async rst wconf_err", werr_w[0], 1'b0);
      check("async rst rd1", rd_w[0][63:32], 32'h0);
      check("async rst rbusy1", rbusy_w[0][1], 1'b0);
      step();
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("pending write lost", rd_w[0][31:0], 32'h0);
      step();

      // Randomized traffic checked by the model every cycle.
      for (int n = 0; n < 3000; n++) begin
         we0 = 1'($urandom_range(0, 1)); wa0 = rnd_addr(); wd0 = $urandom();
         we1 = 1'($urandom_range(0, 1)); wa1 = rnd_addr(); wd1 = $urandom();
         alloc_en = 1'($urandom_range(0, 1)); alloc_addr = rnd_addr();
         ra = {rnd_addr(), rnd_addr()};
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      rst = 1'b0;
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
